// File: rtl/popcnt_pkg.sv
// rtl/popcnt_pkg.sv - shared types and width helpers for the popcount scheduler
package popcnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 16;

  // Result must hold 0..data_w inclusive, hence data_w+1 codes.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting just after the pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    // The last slot visited is the pointer itself, so the previous winner ranks lowest.
    for (int off = 1; off <= N_REQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % N_REQ);
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/popcnt_sched.sv
// rtl/popcnt_sched.sv - one serial ones-counter shared round-robin by N_REQ requesters
module popcnt_sched
  import popcnt_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = cnt_width(DATA_W),
  parameter int ID_W   = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CNT_W-1:0]        res_count,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  ctr_q, ctr_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic [DATA_W-1:0] grant_word;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    grant_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) grant_word = req_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    ctr_d     = ctr_q;
    id_d      = id_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so no grant is advertised while the block is held in reset.
        req_ready = reset ? grant : '0;
        if (grant_any) begin
          shreg_d = grant_word;
          acc_d   = '0;
          ctr_d   = '0;
          id_d    = grant_id;
          ptr_d   = grant_id;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        acc_d   = acc_q + CNT_W'(shreg_q[0]);
        shreg_d = shreg_q >> 1;
        ctr_d   = ctr_q + CNT_W'(1);
        if (ctr_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);
      shreg_q <= '0;
      acc_q   <= '0;
      ctr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == ST_DONE);
  assign res_count = acc_q;
  assign res_id    = id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_popcnt_sched.sv
// tb/tb_popcnt_sched.sv - randomized self-checking bench for popcnt_sched
module tb_popcnt_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_count;
  logic [1:0]  res_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 counting, 2 result offered
  int m_phase, m_ptr, m_left, m_id, m_count;

  always #5 clk = ~clk;

  popcnt_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_id    (res_id),
    .busy      (busy)
  );

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int o = 1; o <= 4; o++) begin
      int i;
      i = (ptr + o) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 3; m_left = 0; m_id = 0; m_count = 0;
  endtask

  task automatic model_edge();
    int g;
    case (m_phase)
      0: begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) begin
          m_ptr = g; m_id = g;
          m_count = $countones(req_data[g*16 +: 16]);
          m_left = 16; m_phase = 1;
        end
      end
      1: begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end
      default: if (res_ready) m_phase = 0;
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic drain();
    req_valid = '0; res_ready = 1'b1;
    for (int c = 0; c < 40 && busy; c++) tick();
  endtask

  task automatic run_one(input int idx, input logic [15:0] w, output int lat,
                         output logic [4:0] cnt, output logic [1:0] id, output logic [3:0] g);
    req_data = {$urandom, $urandom};
    req_data[idx*16 +: 16] = w;
    req_valid = 4'b0001 << idx;
    res_ready = 1'b1;
    #1;
    g = req_ready;
    tick();
    req_valid = '0;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (res_valid) lat = c;
    end
    cnt = res_count;
    id  = res_id;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 4'hF; res_ready = 1'b0; req_data = '0;
    model_reset();
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
    total++; if (res_count !== 5'd0) begin bad++; $display("FAIL reset_res_count: got %0d expected 0", res_count); end
    total++; if (res_id !== 2'd0) begin bad++; $display("FAIL reset_res_id: got %0d expected 0", res_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_single();
    int lat; logic [4:0] cnt; logic [1:0] id; logic [3:0] g;
    run_one(0, 16'h00F0, lat, cnt, id, g);
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b expected 0001", g); end
    total++; if (lat !== 16) begin bad++; $display("FAIL single_latency: got %0d expected 16", lat); end
    total++; if (cnt !== 5'd4) begin bad++; $display("FAIL single_count: got %0d expected 4", cnt); end
    total++; if (id !== 2'd0) begin bad++; $display("FAIL single_id: got %0d expected 0", id); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_release: got %0b expected 0", res_valid); end
  endtask

  task automatic test_extremes();
    int lat; logic [4:0] cnt; logic [1:0] id; logic [3:0] g;
    run_one(1, 16'h0000, lat, cnt, id, g);
    total++; if (cnt !== 5'd0) begin bad++; $display("FAIL zero_count: got %0d expected 0", cnt); end
    total++; if (id !== 2'd1) begin bad++; $display("FAIL zero_id: got %0d expected 1", id); end
    run_one(2, 16'hFFFF, lat, cnt, id, g);
    total++; if (cnt !== 5'd16) begin bad++; $display("FAIL ones_count: got %0d expected 16", cnt); end
    total++; if (id !== 2'd2) begin bad++; $display("FAIL ones_id: got %0d expected 2", id); end
    total++; if (lat !== 16) begin bad++; $display("FAIL ones_latency: got %0d expected 16", lat); end
  endtask

  task automatic test_round_robin();
    int order[$];
    do_reset();
    req_data = {$urandom, $urandom};
    req_valid = 4'hF; res_ready = 1'b1;
    for (int c = 0; c < 300 && order.size() < 5; c++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        total++; if (!$onehot(req_ready)) begin bad++; $display("FAIL rr_onehot: got %b expected one-hot", req_ready); end
        for (int k = 0; k < 4; k++) if (req_ready[k]) order.push_back(k);
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= order.size()) begin bad++; $display("FAIL rr_order[%0d]: got none expected %0d", i, i % 4); end
      else if (order[i] != i % 4) begin bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 4); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    drain();
    req_data = {$urandom, $urandom};
    req_data[48 +: 16] = 16'hA5C3;
    req_valid = 4'b1000; res_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
    tick();
    req_valid = 4'b0011;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (res_valid) lat = c;
    end
    total++; if (lat !== 16) begin bad++; $display("FAIL bp_latency: got %0d expected 16", lat); end
    for (int c = 0; c < 10; c++) begin
      #1;
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d]: got %0b expected 1", c, res_valid); end
      total++; if (res_count !== 5'd8) begin bad++; $display("FAIL bp_hold_count[%0d]: got %0d expected 8", c, res_count); end
      total++; if (res_id !== 2'd3) begin bad++; $display("FAIL bp_hold_id[%0d]: got %0d expected 3", c, res_id); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_no_grant[%0d]: got %b expected 0000", c, req_ready); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %0b expected 0", res_valid); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready); end
    req_valid = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    drain();
    req_data = {$urandom, $urandom};
    req_data[16 +: 16] = 16'hFFFF;
    req_valid = 4'b0010; res_ready = 1'b1;
    #1;
    tick();
    req_valid = '0;
    repeat (7) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %0b expected 1", busy); end
    reset = 1'b0;
    model_reset();
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_res_valid: got %0b expected 0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_grant2: got %b expected 0100", req_ready); end
    req_valid = 4'b0101;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_pointer: got %b expected 0001", req_ready); end
    req_valid = '0;
    #1;
  endtask

  task automatic test_random();
    int results;
    logic [3:0] exp_ready;
    int g;
    do_reset();
    results = 0;
    for (int c = 0; c < 40000 && results < 1000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = {$urandom, $urandom};
      res_ready = 1'($urandom_range(0, 1));
      #1;
      g = pick(req_valid, m_ptr);
      exp_ready = (m_phase == 0 && g >= 0) ? (4'b0001 << g) : 4'b0000;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, req_ready, exp_ready); end
      total++; if (res_valid !== (m_phase == 2)) begin bad++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", c, res_valid, m_phase == 2); end
      total++; if (busy !== (m_phase != 0)) begin bad++; $display("FAIL rnd_busy@%0d: got %0b expected %0b", c, busy, m_phase != 0); end
      if (m_phase == 2) begin
        total++; if (res_count !== 5'(m_count)) begin bad++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, res_count, m_count); end
        total++; if (res_id !== 2'(m_id)) begin bad++; $display("FAIL rnd_id@%0d: got %0d expected %0d", c, res_id, m_id); end
        if (res_ready) results++;
      end
      tick();
    end
    total++; if (results != 1000) begin bad++; $display("FAIL rnd_results: got %0d expected 1000", results); end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
